// File: rtl/transmissor_imagem_serial_pkg.sv
// Shared definitions for the serial image transmitter: FSM state codes,
// UART line levels and the optional frame header bytes.
package transmissor_imagem_serial_pkg;

    // Main FSM; codes are shown on the hex display through db_estado.
    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        LE_PIXEL   = 4'd1,
        ESPERA_MEM = 4'd2,
        ENVIA_MSB  = 4'd3,
        ENVIA_LSB  = 4'd4,
        PROXIMO    = 4'd5,
        FIM        = 4'd6,
        CABECALHO  = 4'd7
    } estado_t;

    // UART byte transmitter phases.
    typedef enum logic [1:0] {
        TX_OCIOSO,
        TX_PARTIDA,
        TX_DADOS,
        TX_PARADA
    } estado_tx_t;

    localparam logic       UART_IDLE = 1'b1;
    localparam logic [7:0] HEADER_B0 = 8'hAA;
    localparam logic [7:0] HEADER_B1 = 8'h55;

endpackage

// File: rtl/transmissor_imagem_serial_tx.sv
// tx_serial_8n1: one 8N1 byte per partida pulse, LSB first, each bit held
// for CLKS_PER_BIT cycles (CLKS_PER_BIT >= 2). The start bit appears on the
// line in the same cycle partida is seen, so a byte can follow the previous
// stop bit with no dead cycle. fim_tx pulses in the final stop-bit cycle.
module tx_serial_8n1
    import transmissor_imagem_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       saida_serial,
    output logic       fim_tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] ULTIMO_CICLO = CNT_W'(CLKS_PER_BIT - 1);

    estado_tx_t       estado;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       deslocador;
    logic             fim_bit;

    assign fim_bit = (cnt == ULTIMO_CICLO);

    // Bit timing, bit index and shift register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= TX_OCIOSO;
            cnt        <= '0;
            bit_idx    <= '0;
            deslocador <= '0;
        end else begin
            case (estado)
                TX_OCIOSO: begin
                    if (partida) begin
                        // The partida cycle already drove the start bit.
                        estado     <= TX_PARTIDA;
                        cnt        <= CNT_W'(1);
                        bit_idx    <= '0;
                        deslocador <= dado;
                    end
                end
                TX_PARTIDA: begin
                    if (fim_bit) begin
                        estado <= TX_DADOS;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DADOS: begin
                    if (fim_bit) begin
                        cnt        <= '0;
                        deslocador <= {1'b0, deslocador[7:1]};
                        bit_idx    <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            estado <= TX_PARADA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_PARADA: begin
                    if (fim_bit) begin
                        estado <= TX_OCIOSO;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: estado <= TX_OCIOSO;
            endcase
        end
    end

    // Line level and end-of-byte pulse from the current phase.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        saida_serial = UART_IDLE;
        fim_tx       = 1'b0;
        case (estado)
            TX_OCIOSO:  saida_serial = partida ? 1'b0 : UART_IDLE;
            TX_PARTIDA: saida_serial = 1'b0;
            TX_DADOS:   saida_serial = deslocador[0];
            TX_PARADA: begin
                saida_serial = 1'b1;
                fim_tx       = fim_bit;
            end
            default:    saida_serial = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/transmissor_imagem_serial.sv
// transmissor_imagem_serial: scans the frame buffer row-major and sends each
// 16-bit pixel as two 8N1 bytes, MSB first, then pulses pronto.
// Optional feature: define FRAME_HEADER_EN to send 0xAA 0x55 before the
// first pixel of every frame.
module transmissor_imagem_serial
    import transmissor_imagem_serial_pkg::*;
#(
    parameter int LINES        = 120,
    parameter int COLUMNS      = 320,
    parameter int S_DATA       = 16,
    parameter int S_LINE       = 7,
    parameter int S_COLUMN     = 9,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    output logic [S_LINE-1:0]   mem_linha,
    output logic [S_COLUMN-1:0] mem_coluna,
    output logic                mem_re,
    input  logic [S_DATA-1:0]   mem_dado,
    output logic                saida_serial,
    output logic                ocupado,
    output logic                pronto,
    output logic [3:0]          db_estado,
    output logic [S_DATA-1:0]   db_pixel
);

    estado_t             estado;
    estado_t             prox_estado;
    logic [S_LINE-1:0]   linha;
    logic [S_COLUMN-1:0] coluna;
    logic [S_DATA-1:0]   pixel;
    logic                byte_em_curso;
    logic                partida;
    logic [7:0]          byte_tx;
    logic                fim_tx;
    logic                ultima_coluna;
    logic                ultimo_pixel;
`ifdef FRAME_HEADER_EN
    logic                idx_cabecalho;
`endif

    assign ultima_coluna = (coluna == S_COLUMN'(COLUMNS - 1));
    assign ultimo_pixel  = ultima_coluna && (linha == S_LINE'(LINES - 1));

    assign mem_linha  = linha;
    assign mem_coluna = coluna;
    assign ocupado    = (estado != OCIOSO);
    assign db_estado  = estado;
    assign db_pixel   = pixel;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next state, memory read strobe, byte launch and frame-done pulse.
    // partida is held off once a byte is in flight so each send state
    // launches exactly one byte.
    always_comb begin
        prox_estado = estado;
        mem_re      = 1'b0;
        pronto      = 1'b0;
        partida     = 1'b0;
        byte_tx     = pixel[15:8];
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
`ifdef FRAME_HEADER_EN
                    prox_estado = CABECALHO;
`else
                    prox_estado = LE_PIXEL;
`endif
                end
            end
            LE_PIXEL: begin
                mem_re      = 1'b1;
                prox_estado = ESPERA_MEM;
            end
            ESPERA_MEM: prox_estado = ENVIA_MSB;
            ENVIA_MSB: begin
                byte_tx = pixel[15:8];
                partida = !byte_em_curso;
                if (fim_tx) prox_estado = ENVIA_LSB;
            end
            ENVIA_LSB: begin
                byte_tx = pixel[7:0];
                partida = !byte_em_curso;
                if (fim_tx) prox_estado = PROXIMO;
            end
            PROXIMO: prox_estado = ultimo_pixel ? FIM : LE_PIXEL;
            FIM: begin
                pronto      = 1'b1;
                prox_estado = OCIOSO;
            end
            CABECALHO: begin
`ifdef FRAME_HEADER_EN
                byte_tx = idx_cabecalho ? HEADER_B1 : HEADER_B0;
                partida = !byte_em_curso;
                if (fim_tx && idx_cabecalho) prox_estado = LE_PIXEL;
`else
                prox_estado = OCIOSO;
`endif
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // Tracks whether the transmitter is busy with the byte of this state.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_em_curso <= 1'b0;
        end else if (fim_tx) begin
            byte_em_curso <= 1'b0;
        end else if (partida) begin
            byte_em_curso <= 1'b1;
        end
    end

`ifdef FRAME_HEADER_EN
    // Selects which header byte is being sent.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_cabecalho <= 1'b0;
        end else if (estado == OCIOSO && iniciar) begin
            idx_cabecalho <= 1'b0;
        end else if (estado == CABECALHO && fim_tx) begin
            idx_cabecalho <= 1'b1;
        end
    end
`endif

    // Row-major address counters: column wraps at COLUMNS-1, then line advances.
    always_ff @(posedge clock) begin
        if (reset) begin
            linha  <= '0;
            coluna <= '0;
        end else if (estado == OCIOSO && iniciar) begin
            linha  <= '0;
            coluna <= '0;
        end else if (estado == PROXIMO && !ultimo_pixel) begin
            if (ultima_coluna) begin
                coluna <= '0;
                linha  <= linha + 1'b1;
            end else begin
                coluna <= coluna + 1'b1;
            end
        end
    end

    // Pixel register: captures the read data one cycle after mem_re.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel <= '0;
        end else if (estado == ESPERA_MEM) begin
            pixel <= mem_dado;
        end
    end

    tx_serial_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida),
        .dado        (byte_tx),
        .saida_serial(saida_serial),
        .fim_tx      (fim_tx)
    );

endmodule

// File: tb/tb_transmissor_imagem_serial.sv
// Bench for transmissor_imagem_serial with a 2x3 frame and 4 clocks per bit.
// Models a 1-cycle-latency RAM returning {linha, coluna} and decodes the UART
// line. Works with or without FRAME_HEADER_EN defined.
module tb_transmissor_imagem_serial;

    localparam int LINES    = 2;
    localparam int COLUMNS  = 3;
    localparam int CLKS     = 4;
    localparam int S_LINE   = 7;
    localparam int S_COLUMN = 9;
    localparam int S_DATA   = 16;
`ifdef FRAME_HEADER_EN
    localparam int OFF = 2;
`else
    localparam int OFF = 0;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                iniciar = 1'b0;
    logic [S_LINE-1:0]   mem_linha;
    logic [S_COLUMN-1:0] mem_coluna;
    logic                mem_re;
    logic [S_DATA-1:0]   mem_dado = '0;
    logic                saida_serial;
    logic                ocupado;
    logic                pronto;
    logic [3:0]          db_estado;
    logic [S_DATA-1:0]   db_pixel;
    logic                a53c = 1'b0;

    always #5 clock = ~clock;

    transmissor_imagem_serial #(
        .LINES(LINES), .COLUMNS(COLUMNS), .S_DATA(S_DATA),
        .S_LINE(S_LINE), .S_COLUMN(S_COLUMN), .CLKS_PER_BIT(CLKS)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .mem_linha(mem_linha), .mem_coluna(mem_coluna), .mem_re(mem_re),
        .mem_dado(mem_dado), .saida_serial(saida_serial), .ocupado(ocupado),
        .pronto(pronto), .db_estado(db_estado), .db_pixel(db_pixel)
    );

    // Frame buffer model: data valid one cycle after mem_re.
    always @(posedge clock) begin
        if (mem_re) begin
            if (a53c && mem_linha == 0 && mem_coluna == 0) mem_dado <= 16'hA53C;
            else mem_dado <= {8'(mem_linha), 8'(mem_coluna)};
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    endtask

    // UART decoder, sampling on the falling edge.
    int dec_st = 0, dec_cnt = 0, dec_bit = 0, gap_cur = 0, dec_gap = 0, ferr = 0;
    int mem_re_cnt = 0, pronto_cnt = 0;
    logic       dec_val;
    logic [7:0] dec_sh;
    logic [9:0] dec_seq;
    logic [7:0] rx_q[$];
    logic [9:0] seq_q[$];
    int         gap_q[$];

    always @(negedge clock) begin
        if (reset) begin
            dec_st  <= 0;
            dec_cnt <= 0;
            gap_cur <= 0;
        end else begin
            case (dec_st)
                0: begin
                    if (saida_serial === 1'b0) begin
                        dec_st  <= 1;
                        dec_cnt <= 1;
                        dec_gap <= gap_cur;
                        dec_seq <= '0;
                    end else begin
                        gap_cur <= gap_cur + 1;
                    end
                end
                1: begin
                    if (saida_serial !== 1'b0) ferr <= ferr + 1;
                    if (dec_cnt == CLKS - 1) begin
                        dec_st  <= 2;
                        dec_cnt <= 0;
                        dec_bit <= 0;
                    end else dec_cnt <= dec_cnt + 1;
                end
                2: begin
                    if (dec_cnt == 0) begin
                        dec_val <= saida_serial;
                        dec_sh  <= {saida_serial, dec_sh[7:1]};
                        dec_seq[dec_bit + 1] <= saida_serial;
                    end else if (saida_serial !== dec_val) ferr <= ferr + 1;
                    if (dec_cnt == CLKS - 1) begin
                        dec_cnt <= 0;
                        if (dec_bit == 7) dec_st <= 3;
                        else dec_bit <= dec_bit + 1;
                    end else dec_cnt <= dec_cnt + 1;
                end
                default: begin
                    if (dec_cnt == 0) dec_seq[9] <= saida_serial;
                    if (saida_serial !== 1'b1) ferr <= ferr + 1;
                    if (dec_cnt == CLKS - 1) begin
                        rx_q.push_back(dec_sh);
                        seq_q.push_back(dec_seq);
                        gap_q.push_back(dec_gap);
                        dec_st  <= 0;
                        dec_cnt <= 0;
                        gap_cur <= 0;
                    end else dec_cnt <= dec_cnt + 1;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_re) mem_re_cnt <= mem_re_cnt + 1;
            if (pronto) pronto_cnt <= pronto_cnt + 1;
        end
    end

    logic [7:0] esperado[$];

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic espera_pronto(input string tag, input int limite);
        int k = 0;
        while (pronto !== 1'b1 && k < limite) begin
            @(negedge clock);
            k++;
        end
        check({tag, " pronto within budget"}, 32'(pronto), 32'd1);
    endtask

    task automatic confere_quadro(input string tag, input int base);
        int gmax = 0;
        check({tag, " byte count"}, 32'(rx_q.size() - base), 32'(esperado.size()));
        for (int i = 0; i < esperado.size(); i++) begin
            if (base + i < rx_q.size()) check($sformatf("%s byte%0d", tag, i), 32'(rx_q[base + i]), 32'(esperado[i]));
            else check($sformatf("%s byte%0d missing", tag, i), 32'h100, 32'(esperado[i]));
        end
        for (int i = 1; i < esperado.size(); i++)
            if (base + i < gap_q.size() && gap_q[base + i] > gmax) gmax = gap_q[base + i];
        check({tag, " max gap <= 3"}, 32'(gmax <= 3), 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       ini;
        logic       serial;
        logic       ocup;
        logic       pron;
        logic       re;
        logic [3:0] est;
    } vetor_t;

    vetor_t tabela[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base2, re0, pr0, baixos, k;

        // Expected byte stream of one frame.
`ifdef FRAME_HEADER_EN
        esperado.push_back(8'hAA);
        esperado.push_back(8'h55);
`endif
        for (int l = 0; l < LINES; l++)
            for (int c = 0; c < COLUMNS; c++) begin
                esperado.push_back(8'(l));
                esperado.push_back(8'(c));
            end

        //               rst   ini   ser   ocup  pron  re    est
        tabela[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tabela[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tabela[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
`ifdef FRAME_HEADER_EN
        tabela[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
        tabela[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
        tabela[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
`else
        tabela[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
        tabela[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        tabela[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
`endif
        tabela[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

        // Reset, start and mid-frame abort, one cycle per vector.
        for (int i = 0; i < 7; i++) begin
            reset   = tabela[i].rst;
            iniciar = tabela[i].ini;
            @(negedge clock);
            check($sformatf("vec%0d saida_serial", i), 32'(saida_serial), 32'(tabela[i].serial));
            check($sformatf("vec%0d ocupado", i), 32'(ocupado), 32'(tabela[i].ocup));
            check($sformatf("vec%0d pronto", i), 32'(pronto), 32'(tabela[i].pron));
            check($sformatf("vec%0d mem_re", i), 32'(mem_re), 32'(tabela[i].re));
            check($sformatf("vec%0d db_estado", i), 32'(db_estado), 32'(tabela[i].est));
        end
        check("reset mem_linha", 32'(mem_linha), 32'd0);
        check("reset mem_coluna", 32'(mem_coluna), 32'd0);
        check("reset db_pixel", 32'(db_pixel), 32'd0);

        // Idle for 50 cycles: line must stay high.
        reset   = 1'b0;
        iniciar = 1'b0;
        baixos  = 0;
        repeat (50) begin
            @(negedge clock);
            if (saida_serial !== 1'b1) baixos++;
        end
        check("idle line low cycles", 32'(baixos), 32'd0);
        check("idle ocupado", 32'(ocupado), 32'd0);

        // Full frame.
        base = rx_q.size();
        re0  = mem_re_cnt;
        pr0  = pronto_cnt;
        pulso_iniciar();
        espera_pronto("frame1", 3000);
        repeat (20) @(negedge clock);
        confere_quadro("frame1", base);
        check("frame1 mem_re pulses", 32'(mem_re_cnt - re0), 32'd6);
        check("frame1 pronto pulses", 32'(pronto_cnt - pr0), 32'd1);
        check("frame1 ocupado after", 32'(ocupado), 32'd0);

        // iniciar repeated mid-frame and again in the pronto cycle.
        base = rx_q.size();
        re0  = mem_re_cnt;
        pr0  = pronto_cnt;
        pulso_iniciar();
        repeat (100) @(negedge clock);
        pulso_iniciar();
        espera_pronto("repulse", 3000);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (20) @(negedge clock);
        confere_quadro("repulse", base);
        check("repulse mem_re pulses", 32'(mem_re_cnt - re0), 32'd6);
        check("repulse pronto pulses", 32'(pronto_cnt - pr0), 32'd1);
        check("repulse db_estado idle", 32'(db_estado), 32'd0);

        // Pixel 0xA53C at (0,0).
        a53c = 1'b1;
        base = rx_q.size();
        pulso_iniciar();
        k = 0;
        while (db_estado !== 4'd3 && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("a53c reached ENVIA_MSB", 32'(db_estado), 32'd3);
        check("a53c db_pixel", 32'(db_pixel), 32'hA53C);
        espera_pronto("a53c", 3000);
        repeat (10) @(negedge clock);
        if (rx_q.size() > base + OFF + 1) begin
            check("a53c msb byte", 32'(rx_q[base + OFF]), 32'hA5);
            check("a53c lsb byte", 32'(rx_q[base + OFF + 1]), 32'h3C);
            check("a53c line sequence", 32'(seq_q[base + OFF]), 32'(10'b1101001010));
        end else begin
            check("a53c bytes received", 32'(rx_q.size() - base), 32'(OFF + 2));
        end
        a53c = 1'b0;

        // Reset during the 5th byte, then restart from (0,0).
        base = rx_q.size();
        pulso_iniciar();
        k = 0;
        while (rx_q.size() < base + 4 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("abort four bytes sent", 32'(rx_q.size() >= base + 4), 32'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort saida_serial", 32'(saida_serial), 32'd1);
        check("abort ocupado", 32'(ocupado), 32'd0);
        check("abort db_estado", 32'(db_estado), 32'd0);
        check("abort mem_re", 32'(mem_re), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("abort mem_linha", 32'(mem_linha), 32'd0);
        check("abort mem_coluna", 32'(mem_coluna), 32'd0);
        check("abort no partial byte", 32'(rx_q.size() - base), 32'd4);
        base2 = rx_q.size();
        pulso_iniciar();
        espera_pronto("restart", 3000);
        repeat (20) @(negedge clock);
        confere_quadro("restart", base2);

        check("uart framing errors", 32'(ferr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
